// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared types, CRC constants and single-bit CRC step functions
// for the USB transmit CRC generator.
//   pkt_t      - packet type code carried on pkt_in
//   crc5_next  - advance a CRC5 register by one serial bit
//   crc16_next - advance a CRC16 register by one serial bit
package usb_crc_pkg;

  typedef enum logic [1:0] {
    PktNone   = 2'b00,
    PktToken  = 2'b01,
    PktHshake = 2'b10,
    PktData   = 2'b11
  } pkt_t;

  localparam logic [4:0]  CRC5_POLY  = 5'b00101;   // x^5 + x^2 + 1
  localparam logic [15:0] CRC16_POLY = 16'h8005;   // x^16 + x^15 + x^2 + 1
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // MSB of the register is the oldest term; the incoming bit is folded into feedback.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic din);
    logic fb;
    fb = crc[4] ^ din;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b0);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'b0);
  endfunction

endpackage

// File: rtl/usb_crc_tx_bit_fifo.sv
// bit_fifo: single-bit-wide synchronous FIFO, power-of-two depth.
//   clk, rst_n     - clock, asynchronous active-low reset (flushes contents)
//   we, bit_in     - write strobe and data; ignored while full
//   re, bit_out    - read strobe and head bit; read ignored while empty
//   full, empty    - occupancy flags
//   count          - current occupancy, 0..DEPTH
module bit_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic                     bit_in,
  output logic                     bit_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign bit_out = mem_q[rd_ptr_q];

  assign do_wr = we & ~full;
  assign do_rd = re & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = bit_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);  // wraps at DEPTH
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/usb_crc_tx.sv
// usb_crc_tx: CRC generator and serial bit buffer for the USB transmit path.
// Header bits pass through uncovered, payload bits are CRC'd (CRC5 for TOKEN,
// CRC16 for DATA) and the complemented remainder is appended MSB first.
//   clk, rst_n              - clock, asynchronous active-low reset
//   pkt_in                  - packet type, sampled in IDLE only
//   s_in, s_valid, endr     - serial input bit, valid, last-bit marker
//   s_ready                 - input accepted this cycle when high with s_valid
//   pause                   - downstream stall, no FIFO read while high
//   s_out, out_valid        - FIFO head bit and its valid
//   start_b, endb           - one-cycle packet start / packet delivered pulses
module usb_crc_tx
  import usb_crc_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned HDR_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pkt_in,
  input  logic       s_in,
  input  logic       s_valid,
  input  logic       endr,
  output logic       s_ready,
  input  logic       pause,
  output logic       s_out,
  output logic       out_valid,
  output logic       start_b,
  output logic       endb
);

  localparam int unsigned CW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(HDR_BITS + 1);
  localparam logic [HW-1:0] HdrLast = HW'(HDR_BITS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHdr     = 3'd1;
  localparam logic [2:0] StPayload = 3'd2;
  localparam logic [2:0] StAppend  = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  logic [2:0]    state_q, state_d;
  pkt_t          pkt_q, pkt_d;
  logic [15:0]   crc_q, crc_d;
  logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [4:0]    app_cnt_q, app_cnt_d;
  logic          started_q, started_d;
  logic          start_b_q, start_b_d;

  logic          fifo_we, fifo_re, fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   fifo_count;

  logic          accept;
  logic          hdr_accept;
  logic [HW-1:0] hdr_idx;
  pkt_t          pkt_sel;
  logic [4:0]    app_len;
  logic [3:0]    app_idx;

  assign s_ready   = ~fifo_full &
                     ((state_q == StIdle) | (state_q == StHdr) | (state_q == StPayload));
  assign accept    = s_valid & s_ready;
  assign out_valid = ~fifo_empty & started_q;
  assign fifo_re   = out_valid & ~pause;
  assign s_out     = out_valid & fifo_dout;
  assign start_b   = start_b_q;
  assign endb      = (state_q == StDrain) & (fifo_count == '0);

  // In IDLE the type comes straight from pkt_in so the same-cycle bit is header bit 0.
  assign pkt_sel    = (state_q == StIdle) ? pkt_t'(pkt_in) : pkt_q;
  assign hdr_idx    = (state_q == StIdle) ? '0 : hdr_cnt_q;
  assign hdr_accept = accept & ((state_q == StHdr) |
                                ((state_q == StIdle) & (pkt_in != PktNone)));
  assign app_len    = (pkt_sel == PktToken) ? 5'd5 : 5'd16;
  // app_cnt of 16 wraps to index 15, so one subtractor serves both widths.
  assign app_idx    = app_cnt_q[3:0] - 4'd1;

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    crc_d     = crc_q;
    hdr_cnt_d = hdr_cnt_q;
    app_cnt_d = app_cnt_q;
    started_d = started_q;
    start_b_d = 1'b0;
    fifo_we   = 1'b0;
    fifo_din  = s_in;

    unique case (state_q)
      StIdle: begin
        if (pkt_in != PktNone) begin
          pkt_d     = pkt_t'(pkt_in);
          crc_d     = (pkt_in == PktToken) ? {11'h7FF, CRC5_INIT} : CRC16_INIT;
          hdr_cnt_d = '0;
          state_d   = StHdr;
        end
      end
      StHdr: ;  // header handling shared with IDLE below
      StPayload: begin
        if (accept) begin
          fifo_we = 1'b1;
          if (pkt_q == PktToken) begin
            crc_d[4:0] = crc5_next(crc_q[4:0], s_in);
          end else if (pkt_q == PktData) begin
            crc_d = crc16_next(crc_q, s_in);
          end
          if (endr) begin
            state_d   = (pkt_q == PktHshake) ? StDrain : StAppend;
            app_cnt_d = app_len;
          end
        end
      end
      StAppend: begin
        if (!fifo_full) begin
          fifo_we   = 1'b1;
          fifo_din  = ~crc_q[app_idx];
          app_cnt_d = app_cnt_q - 5'd1;
          if (app_cnt_q == 5'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_count == '0) begin
          state_d   = StIdle;
          started_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (hdr_accept) begin
      fifo_we   = 1'b1;
      hdr_cnt_d = hdr_idx + HW'(1);
      if (hdr_idx == HdrLast) begin
        start_b_d = 1'b1;
        started_d = 1'b1;
        if (endr) begin
          state_d   = (pkt_sel == PktHshake) ? StDrain : StAppend;
          app_cnt_d = app_len;
        end else begin
          state_d = StPayload;
        end
      end else if (endr) begin
        // Short packet: behaves as a handshake, no CRC appended.
        start_b_d = 1'b1;
        started_d = 1'b1;
        state_d   = StDrain;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pkt_q     <= PktNone;
      crc_q     <= CRC16_INIT;
      hdr_cnt_q <= '0;
      app_cnt_q <= '0;
      started_q <= 1'b0;
      start_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      crc_q     <= crc_d;
      hdr_cnt_q <= hdr_cnt_d;
      app_cnt_q <= app_cnt_d;
      started_q <= started_d;
      start_b_q <= start_b_d;
    end
  end

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_bit_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (fifo_we),
    .re      (fifo_re),
    .bit_in  (fifo_din),
    .bit_out (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_usb_crc_tx.sv
// tb_usb_crc_tx: directed and randomised checks of usb_crc_tx output streams,
// pulses, backpressure and reset behaviour against an independent reflected
// (LSB-first) CRC model.
module tb_usb_crc_tx;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned HDR_BITS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pkt_in = 2'b00;
  logic       s_in = 1'b0;
  logic       s_valid = 1'b0;
  logic       endr = 1'b0;
  logic       pause = 1'b0;
  logic       s_ready, s_out, out_valid, start_b, endb;

  always #5 clk = ~clk;

  usb_crc_tx #(
    .DEPTH    (DEPTH),
    .HDR_BITS (HDR_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkt_in    (pkt_in),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .endr      (endr),
    .s_ready   (s_ready),
    .pause     (pause),
    .s_out     (s_out),
    .out_valid (out_valid),
    .start_b   (start_b),
    .endb      (endb)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cnt = 0;
  int endb_cnt = 0;
  int last_rd_cyc = 0;
  int endb_cyc = 0;
  int acc_cnt = 0;
  int bp_low_at = -1;
  bit bp_watch = 1'b0;
  bit rand_pause = 1'b0;
  bit drv_q[$];
  bit got_q[$];
  bit exp_q[$];

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_pause) begin
      #1;
      pause = ($urandom_range(3) == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !pause) begin
        got_q.push_back(s_out);
        last_rd_cyc = cyc;
      end
      if (start_b) start_cnt++;
      if (endb) begin
        endb_cnt++;
        endb_cyc = cyc;
      end
      if (bp_watch && !s_ready && bp_low_at < 0) bp_low_at = acc_cnt;
    end
  end

  function automatic logic [159:0] q2v(input bit q[$]);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 160; i++) v[i] = q[i];
    return v;
  endfunction

  // Reflected form: register is the bit-reverse of the MSB-first register.
  function automatic logic [15:0] refl_step(input logic [15:0] r, input bit b, input int w);
    logic        fb;
    logic [15:0] n;
    fb = r[0] ^ b;
    n  = r >> 1;
    if (fb) n = n ^ ((w == 5) ? 16'h0014 : 16'hA001);
    return n;
  endfunction

  function automatic logic [15:0] rev_bits(input logic [15:0] v, input int w);
    logic [15:0] o;
    o = '0;
    for (int k = 0; k < w; k++) o[k] = v[w-1-k];
    return o;
  endfunction

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) drv_q.push_back(v[i]);
  endtask

  task automatic new_pkt();
    drv_q.delete();
    got_q.delete();
    start_cnt = 0;
    endb_cnt  = 0;
  endtask

  task automatic build_exp(input logic [1:0] ty);
    logic [15:0] r;
    int          w;
    exp_q = drv_q;
    if (ty == 2'b01 || ty == 2'b11) begin
      w = (ty == 2'b01) ? 5 : 16;
      r = (ty == 2'b01) ? 16'h001F : 16'hFFFF;
      for (int i = HDR_BITS; i < drv_q.size(); i++) r = refl_step(r, drv_q[i], w);
      for (int k = 0; k < w; k++) exp_q.push_back(~r[k]);
    end
  endtask

  // Called at posedge+1; bits of drv_q are offered until each is accepted.
  task automatic send_pkt(input logic [1:0] ty, input bit rand_valid);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    pkt_in = ty;
    while (i < drv_q.size()) begin
      s_valid = (i == 0) ? 1'b1 : (rand_valid ? ($urandom_range(2) != 0) : 1'b1);
      s_in    = drv_q[i];
      endr    = (i == int'(drv_q.size()) - 1);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      pkt_in = 2'b00;
      if (acc) begin
        i++;
        acc_cnt++;
        guard = 0;
      end else if (++guard > 500) begin
        check_eq("send_timeout", i, drv_q.size());
        break;
      end
    end
    s_valid = 1'b0;
    endr    = 1'b0;
  endtask

  task automatic wait_endb(input string tag);
    int t;
    t = 0;
    while (endb_cnt == 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_endb_cnt"}, endb_cnt, 1);
    check_eq({tag, "_start_cnt"}, start_cnt, 1);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    check_eq({tag, "_bits"}, q2v(got_q), q2v(exp_q));
  endtask

  task automatic check_residue(input string tag, input logic [1:0] ty);
    logic [15:0] r;
    int          w;
    w = (ty == 2'b01) ? 5 : 16;
    r = (ty == 2'b01) ? 16'h001F : 16'hFFFF;
    for (int i = HDR_BITS; i < got_q.size(); i++) r = refl_step(r, got_q[i], w);
    check_eq({tag, "_residue"}, r, rev_bits((w == 5) ? 16'h000C : 16'h800D, w));
  endtask

  initial begin
    logic [1:0] ty;
    int         plen;

    // Reset values
    #2;
    check_eq("rst_outs", {s_ready, out_valid, s_out, start_b, endb}, 5'b10000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", {s_ready, out_valid, s_out, start_b, endb}, 5'b10000);
    @(posedge clk);
    #1;

    // TOKEN addr=0x15 endp=0xE: appended 1,0,1,1,1
    new_pkt();
    push_bits(64'h0000_0000_0000_D280, 16);
    push_bits(64'h15, 7);
    push_bits(64'hE, 4);
    exp_q = drv_q;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    send_pkt(2'b01, 1'b0);
    wait_endb("token");
    check_eq("token_len32", got_q.size(), 32);
    check_stream("token");
    check_eq("token_endb_gap", endb_cyc - last_rd_cyc, 1);

    // DATA with empty payload: 16 zero CRC bits
    new_pkt();
    push_bits(64'h0000_0000_0000_C380, 16);
    exp_q = drv_q;
    for (int k = 0; k < 16; k++) exp_q.push_back(1'b0);
    send_pkt(2'b11, 1'b0);
    wait_endb("edata");
    check_stream("edata");
    check_eq("edata_endb_gap", endb_cyc - last_rd_cyc, 1);

    // HSHAKE: bits through unchanged
    new_pkt();
    push_bits(64'h0000_0000_0000_D280, 16);
    exp_q = drv_q;
    send_pkt(2'b10, 1'b0);
    wait_endb("hshake");
    check_stream("hshake");

    // Backpressure: pause held for 40 cycles from packet start
    new_pkt();
    push_bits(64'h0000_0000_0000_C380, 16);
    push_bits({$urandom(), $urandom()}, 64);
    build_exp(2'b11);
    pause     = 1'b1;
    acc_cnt   = 0;
    bp_low_at = -1;
    bp_watch  = 1'b1;
    fork
      send_pkt(2'b11, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #1;
        pause = 1'b0;
      end
    join
    wait_endb("bp");
    bp_watch = 1'b0;
    check_eq("bp_ready_drop_at", bp_low_at, DEPTH);
    check_stream("bp");
    check_residue("bp", 2'b11);

    // Reset during APPEND
    new_pkt();
    push_bits(64'h0000_0000_0000_C380, 16);
    push_bits(64'hA5, 8);
    send_pkt(2'b11, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outs", {s_ready, out_valid, s_out, start_b, endb}, 5'b10000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("rst_mid_no_endb", endb_cnt, 0);
    new_pkt();
    push_bits(64'h0000_0000_0000_D280, 16);
    push_bits(64'h3A, 7);
    push_bits(64'h5, 4);
    build_exp(2'b01);
    send_pkt(2'b01, 1'b0);
    wait_endb("post_rst");
    check_stream("post_rst");
    check_residue("post_rst", 2'b01);

    // Random pause / s_valid over mixed TOKEN and DATA packets
    rand_pause = 1'b1;
    for (int p = 0; p < 24; p++) begin
      ty   = ($urandom_range(1) == 0) ? 2'b01 : 2'b11;
      plen = (ty == 2'b01) ? 11 : int'($urandom_range(48));
      new_pkt();
      push_bits({48'h0, $urandom_range(65535)}, 16);
      push_bits({$urandom(), $urandom()}, plen);
      build_exp(ty);
      send_pkt(ty, 1'b1);
      wait_endb("rnd");
      check_stream("rnd");
      check_residue("rnd", ty);
    end
    rand_pause = 1'b0;
    #1;
    pause = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
